target_slew: RTL

TARGET_SLEW -- requirements
Module: target_slew

---
 rtl/anspwm_pkg.sv | 5 +
 rtl/target_debounce.sv | 39 +++
 rtl/target_slew.sv | 95 +++++++++
 3 files changed

// File: rtl/anspwm_pkg.sv
// anspwm_pkg: shared slew FSM state type and default data width.
package anspwm_pkg;
    typedef enum logic [1:0] {IDLE, UP, DOWN, SETTLE} state_t;
    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/target_debounce.sv
// target_debounce: passes din to dout only after it has been stable for DEBOUNCE_CYCLES clocks.
// Used by target_slew when TARGET_SLEW_DEBOUNCE_EN is defined.
module target_debounce import anspwm_pkg::*; #(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_dout;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    // The candidate always ends up equal to din; only the counter distinguishes a change.
    always_comb begin
        w_cnt_nxt = (din != r_cand) ? '0 :
                    (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            r_cand <= din;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CW'(DEBOUNCE_CYCLES - 1))
                r_dout <= din;
        end
    end

    assign dout = r_dout;
endmodule

// File: rtl/target_slew.sv
// target_slew: rate-limits target_out towards the accepted target by at most STEP per tick.
// Define TARGET_SLEW_DEBOUNCE_EN to debounce target_in before acceptance.
module target_slew import anspwm_pkg::*; #(
    parameter int          WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned STEP            = 1024,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target_in,
    input  logic             tick,
    output logic [WIDTH-1:0] target_out,
    output logic             busy,
    output logic             settled
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_accepted;
    logic [WIDTH-1:0] w_up_gap;
    logic [WIDTH-1:0] w_dn_gap;

`ifdef TARGET_SLEW_DEBOUNCE_EN
    target_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk(clk),
        .rst_n(rst_n),
        .din(target_in),
        .dout(w_accepted)
    );
`else
    logic [WIDTH-1:0] r_accepted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_accepted <= '0;
        else
            r_accepted <= target_in;
    end

    assign w_accepted = r_accepted;
`endif

    assign w_up_gap = w_accepted - r_out;
    assign w_dn_gap = r_out - w_accepted;

    // A gap within STEP lands exactly on the goal, so the output can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        case (r_state)
            IDLE: w_state_nxt = (w_accepted > r_out) ? UP : (w_accepted < r_out) ? DOWN : IDLE;
            UP: begin
                if (w_accepted < r_out)
                    w_state_nxt = DOWN;
                else if (w_accepted == r_out)
                    w_state_nxt = SETTLE;
                else if (tick) begin
                    w_out_nxt   = (w_up_gap <= STEP_W) ? w_accepted : r_out + STEP_W;
                    w_state_nxt = (w_up_gap <= STEP_W) ? SETTLE : UP;
                end
            end
            DOWN: begin
                if (w_accepted > r_out)
                    w_state_nxt = UP;
                else if (w_accepted == r_out)
                    w_state_nxt = SETTLE;
                else if (tick) begin
                    w_out_nxt   = (w_dn_gap <= STEP_W) ? w_accepted : r_out - STEP_W;
                    w_state_nxt = (w_dn_gap <= STEP_W) ? SETTLE : DOWN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign target_out = r_out;
    assign busy       = (r_state == UP) || (r_state == DOWN);
    assign settled    = (r_state == SETTLE);
endmodule
